axi_lite_perip_slave: RTL and testbench
=======================================

# axi_lite_perip_slave

AXI4-Lite responder that terminates the datapath's data-side AXI4-Lite initiator and drives the simple single-port peripheral bus (`perip_addr`, `perip_wen`, `perip_mask`, `perip_wdata`, `perip_rdata`). It replaces the ad-hoc read-valid FSM and strobe-to-mask decode in the FPGA top. It serialises reads and writes, applies a fixed peripheral read latency, and holds responses until accepted.

## Interface
- `RD_LATENCY`, 2: peripheral read latency in cycles (≥1), counted from the first cycle `perip_addr` is presented to the cycle `perip_rdata` is sampled.
- `ADDR_BASE`, 32'h8000_0000: legal window base (used only with the range check).
- `ADDR_MASK`, 32'hFFF0_0000: legal window mask (used only with the range check).
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_araddr` in 32, `s_arvalid` in 1, `s_arready` out 1: AR channel.
- `s_rdata` out 32, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1: R channel.
- `s_awaddr` in 32, `s_awvalid` in 1, `s_awready` out 1: AW channel.
- `s_wdata` in 32, `s_wstrb` in 4, `s_wvalid` in 1, `s_wready` out 1: W channel.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1: B channel.
- `perip_addr` out 32: registered access address.
- `perip_wen` out 1: one-cycle write pulse.
- `perip_mask` out 2: 00 byte, 01 half, 10 word, 11 none.
- `perip_wdata` out 32: write data.
- `perip_rdata` in 32: read data.

## Operation
- States: IDLE, RD_WAIT, RD_RESP, WR_PULSE, WR_RESP.
- IDLE, read grant: `s_arvalid`=1 and (no write pending, or `last_rd`=0). Assert `s_arready` combinationally, latch `s_araddr`, load the latency counter with RD_LATENCY, and go to RD_WAIT.
- IDLE, write grant: `s_awvalid` and `s_wvalid` both 1, and (no read pending, or `last_rd`=1). Assert `s_awready` and `s_wready` together in the same cycle; never accept one without the other. Latch addr/data/strb and go to WR_PULSE.
- Arbitration: `last_rd` flips on every grant, giving round-robin between reads and writes. When both are requested in the first cycle out of reset, read wins (`last_rd` resets to 0).
- RD_WAIT: `perip_addr` holds the latched addr and `perip_mask`=11. The counter decrements each cycle. When the counter reaches 1, capture `perip_rdata` into `s_rdata`, set `s_rresp`=00, and go to RD_RESP.
- RD_RESP: `s_rvalid`=1 with stable data until `s_rready`, then return to IDLE.
- WR_PULSE: decode strobe: 0001→00, 0011→01, 1111→10.
  - Legal strobe: `perip_wen`=1 for exactly this cycle; `bresp`=00.
  - Any other strobe: `perip_wen` stays 0, `perip_mask`=11, `bresp`=SLVERR (10).
  - Go to WR_RESP.
- WR_RESP: `s_bvalid`=1 until `s_bready`, then return to IDLE.
- No `*ready` is asserted outside IDLE, so at most one transaction is outstanding.
- Reset values: all `s_*ready`/`s_*valid` 0, `s_rdata` 0, `s_rresp`/`s_bresp` 00, `perip_addr` 0, `perip_wdata` 0, `perip_wen` 0, `perip_mask` 11, state IDLE, `last_rd` 0.
- Reset mid-transaction: the outstanding transaction is dropped, no response is issued, and `perip_wen` is low from the reset edge onward.

## Timing
- Read: AR handshake in cycle T. `perip_addr` is valid from T+1. `perip_rdata` is sampled in cycle T+RD_LATENCY. `s_rvalid` is high from T+RD_LATENCY+1.
- Back-to-back reads: the next `s_arready` can assert at the earliest in the cycle after the R handshake.
- Write: AW/W handshake in T. `perip_wen` pulses in T+1. `s_bvalid` is high from T+2.
- `s_rready`/`s_bready` already high when valid rises completes the handshake in that same cycle.
- All outputs except the `*ready` signals are registered.

## Configuration
- `PERIP_RANGE_CHECK_EN` defined: compute `(addr & ADDR_MASK) != (ADDR_BASE & ADDR_MASK)` at accept.
  - Out-of-range read: skip RD_WAIT, go directly to RD_RESP with `s_rdata`=0 and `s_rresp`=DECERR (11); `s_rvalid` is high at T+1.
  - Out-of-range write: no `perip_wen` pulse, `bresp`=11.
- Not defined: every address is forwarded, DECERR is never produced, and `ADDR_BASE`/`ADDR_MASK` are ignored.

## Structure
- Shared package `axi_lite_pkg`: response codes (OKAY 00, SLVERR 10, DECERR 11), perip mask encodings (BYTE 00, HALF 01, WORD 10, NONE 11), and the state enum.
- Sub-module `perip_wstrb_decode`: combinational `wstrb` → {mask, legal}. It is reused by the FPGA top.

## Test plan
- Read at RD_LATENCY=2: AR addr 0x8000_0010 in T, memory model returns 0xDEADBEEF → `perip_addr`=0x8000_0010 from T+1, `s_rvalid` at T+3 with `rdata`=0xDEADBEEF, `rresp`=00.
- Word write: AW 0x8000_0004, W 0x1234_5678, `wstrb` 1111 in T → `perip_wen` only in T+1 with mask 10 and the matching addr/data; `bvalid` at T+2 with `bresp`=00.
- Illegal strobe 0101 → `perip_wen` never asserts and `bresp`=10; a following strobe 0001 write succeeds with mask 00.
- Simultaneous AR and AW/W, repeated 4 times with `rready`/`bready` held 0 for 3 cycles each time → grants alternate R,W,R,W; each response stays stable while stalled.
- Reset asserted in RD_WAIT and again in WR_PULSE → no `rvalid`/`bvalid`; `perip_wen`=0 and `perip_mask`=11 after the edge; a fresh read then completes normally.
- With `PERIP_RANGE_CHECK_EN`: read of 0x0000_1000 → `rvalid` at T+1 with `rresp`=11 and `rdata`=0; write of 0x0000_1000 → no `perip_wen`, `bresp`=11.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite / peripheral-bus definitions: response codes, peripheral
// mask encodings, responder state enum and the address-window helper.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] MASK_BYTE = 2'b00;
   localparam logic [1:0] MASK_HALF = 2'b01;
   localparam logic [1:0] MASK_WORD = 2'b10;
   localparam logic [1:0] MASK_NONE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_WAIT  = 3'd1,
      ST_RD_RESP  = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_RESP  = 3'd4
   } state_e;

   function automatic logic addr_out_of_range(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input logic [31:0] mask);
      return (addr & mask) != (base & mask);
   endfunction

endpackage

// File: rtl/axi_lite_perip_slave_if.sv
// Bundle of the AXI4-Lite responder channels and the single-port peripheral
// bus; the slave modport is the responder's view, master the initiator's.
interface axi_lite_perip_slave_if;

   // Every channel transfers on a rising clk edge where valid and ready are
   // both high; a valid, once raised, holds with stable payload until then.
   logic [31:0] s_araddr;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready;
   logic [31:0] s_awaddr;
   logic        s_awvalid;
   logic        s_awready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wvalid;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready;
   logic [31:0] perip_addr;
   logic        perip_wen;
   logic [1:0]  perip_mask;
   logic [31:0] perip_wdata;
   logic [31:0] perip_rdata;

   modport slave (
      input  s_araddr, s_arvalid, s_rready,
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
      input  perip_rdata,
      output s_arready, s_rdata, s_rresp, s_rvalid,
      output s_awready, s_wready, s_bresp, s_bvalid,
      output perip_addr, perip_wen, perip_mask, perip_wdata
   );

   modport master (
      output s_araddr, s_arvalid, s_rready,
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
      output perip_rdata,
      input  s_arready, s_rdata, s_rresp, s_rvalid,
      input  s_awready, s_wready, s_bresp, s_bvalid,
      input  perip_addr, perip_wen, perip_mask, perip_wdata
   );

endinterface

// File: rtl/perip_wstrb_decode.sv
// Combinational AXI write-strobe to peripheral-mask decode; only the
// low-aligned byte, half and full-word strobes are representable.
module perip_wstrb_decode
   import axi_lite_pkg::*;
(
   input  logic [3:0] wstrb_i,
   output logic [1:0] mask_o,
   output logic       legal_o
);

   always_comb begin
      mask_o  = MASK_NONE;
      legal_o = 1'b0;
      case (wstrb_i)
         4'b0001: begin mask_o = MASK_BYTE; legal_o = 1'b1; end
         4'b0011: begin mask_o = MASK_HALF; legal_o = 1'b1; end
         4'b1111: begin mask_o = MASK_WORD; legal_o = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/axi_lite_perip_slave.sv
// AXI4-Lite responder driving a single-port peripheral bus, one transaction at
// a time. Optional address-window check enabled by PERIP_RANGE_CHECK_EN.
module axi_lite_perip_slave
   import axi_lite_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 2,
   parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
   parameter logic [31:0] ADDR_MASK  = 32'hFFF0_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   axi_lite_perip_slave_if.slave bus,
   output state_e               dbg_state_o
);

   localparam int CNT_W = $clog2(RD_LATENCY + 1);

`ifdef PERIP_RANGE_CHECK_EN
   localparam bit RANGE_CHK = 1'b1;
`else
   localparam bit RANGE_CHK = 1'b0;
`endif

   state_e             state_q, state_d;
   logic               last_rd_q, last_rd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [1:0]         rresp_q, rresp_d;
   logic [1:0]         bresp_q, bresp_d;
   logic [1:0]         mask_q, mask_d;
   logic               wen_q, wen_d;
   logic               rvalid_q, rvalid_d;
   logic               bvalid_q, bvalid_d;

   logic               idle, rd_req, wr_req, rd_grant, wr_grant;
   logic               rd_oor, wr_oor;
   logic [1:0]         dec_mask;
   logic               dec_legal;

   perip_wstrb_decode u_wstrb_decode (
      .wstrb_i (bus.s_wstrb),
      .mask_o  (dec_mask),
      .legal_o (dec_legal)
   );

   // Round-robin: on contention the side that did not win last time is granted.
   assign idle     = (state_q == ST_IDLE);
   assign rd_req   = bus.s_arvalid;
   assign wr_req   = bus.s_awvalid & bus.s_wvalid;
   assign rd_grant = idle & rd_req & (~wr_req | ~last_rd_q);
   assign wr_grant = idle & wr_req & (~rd_req |  last_rd_q);

   assign rd_oor = RANGE_CHK && addr_out_of_range(bus.s_araddr, ADDR_BASE, ADDR_MASK);
   assign wr_oor = RANGE_CHK && addr_out_of_range(bus.s_awaddr, ADDR_BASE, ADDR_MASK);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_grant)      state_d = rd_oor ? ST_RD_RESP : ST_RD_WAIT;
            else if (wr_grant) state_d = ST_WR_PULSE;
         end
         ST_RD_WAIT:  if (cnt_q == CNT_W'(1)) state_d = ST_RD_RESP;
         ST_RD_RESP:  if (bus.s_rready) state_d = ST_IDLE;
         ST_WR_PULSE: state_d = ST_WR_RESP;
         ST_WR_RESP:  if (bus.s_bready) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      last_rd_d = last_rd_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      bresp_d   = bresp_q;
      mask_d    = mask_q;
      wen_d     = 1'b0;
      rvalid_d  = rvalid_q;
      bvalid_d  = bvalid_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_grant) begin
               last_rd_d = ~last_rd_q;
               addr_d    = bus.s_araddr;
               mask_d    = MASK_NONE;
               cnt_d     = CNT_W'(RD_LATENCY);
               if (rd_oor) begin
                  rdata_d  = '0;
                  rresp_d  = RESP_DECERR;
                  rvalid_d = 1'b1;
               end
            end else if (wr_grant) begin
               last_rd_d = ~last_rd_q;
               addr_d    = bus.s_awaddr;
               wdata_d   = bus.s_wdata;
               if (wr_oor) begin
                  mask_d  = MASK_NONE;
                  bresp_d = RESP_DECERR;
               end else if (dec_legal) begin
                  wen_d   = 1'b1;
                  mask_d  = dec_mask;
                  bresp_d = RESP_OKAY;
               end else begin
                  mask_d  = MASK_NONE;
                  bresp_d = RESP_SLVERR;
               end
            end
         end
         ST_RD_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               rdata_d  = bus.perip_rdata;
               rresp_d  = RESP_OKAY;
               rvalid_d = 1'b1;
            end
         end
         ST_RD_RESP:  if (bus.s_rready) rvalid_d = 1'b0;
         ST_WR_PULSE: begin
            mask_d   = MASK_NONE;
            bvalid_d = 1'b1;
         end
         ST_WR_RESP:  if (bus.s_bready) bvalid_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_rd_q <= 1'b0;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         bresp_q   <= RESP_OKAY;
         mask_q    <= MASK_NONE;
         wen_q     <= 1'b0;
         rvalid_q  <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         last_rd_q <= last_rd_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         bresp_q   <= bresp_d;
         mask_q    <= mask_d;
         wen_q     <= wen_d;
         rvalid_q  <= rvalid_d;
         bvalid_q  <= bvalid_d;
      end
   end

   assign bus.s_arready   = rd_grant;
   assign bus.s_awready   = wr_grant;
   assign bus.s_wready    = wr_grant;
   assign bus.s_rdata     = rdata_q;
   assign bus.s_rresp     = rresp_q;
   assign bus.s_rvalid    = rvalid_q;
   assign bus.s_bresp     = bresp_q;
   assign bus.s_bvalid    = bvalid_q;
   assign bus.perip_addr  = addr_q;
   assign bus.perip_wen   = wen_q;
   assign bus.perip_mask  = mask_q;
   assign bus.perip_wdata = wdata_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_axi_lite_perip_slave.sv
// Directed bench for axi_lite_perip_slave: reads, writes, strobe decode,
// arbitration, mid-transaction reset and (when defined) PERIP_RANGE_CHECK_EN.
module tb_axi_lite_perip_slave;
   import axi_lite_pkg::*;

   localparam int unsigned RL = 2;

   logic   clk = 1'b0;
   logic   rst;
   state_e dbg_state;
   int     n_checks = 0;
   int     n_pass   = 0;
   int unsigned age;

   axi_lite_perip_slave_if bus();

   axi_lite_perip_slave #(
      .RD_LATENCY (RL),
      .ADDR_BASE  (32'h8000_0000),
      .ADDR_MASK  (32'hFFF0_0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   // Peripheral model: data is only valid in the RL-th cycle after AR acceptance.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8000_0010) return 32'hDEAD_BEEF;
      return a ^ 32'hA5A5_0000;
   endfunction

   always @(posedge clk) begin
      if (rst) age <= 0;
      else if (bus.s_arvalid && bus.s_arready) age <= 1;
      else if (age != 0 && age < 100) age <= age + 1;
   end

   assign bus.perip_rdata = (age == RL) ? mem_word(bus.perip_addr) : 32'hBAD0_BAD0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic idle_inputs();
      bus.s_araddr  = '0;
      bus.s_arvalid = 1'b0;
      bus.s_rready  = 1'b0;
      bus.s_awaddr  = '0;
      bus.s_awvalid = 1'b0;
      bus.s_wdata   = '0;
      bus.s_wstrb   = '0;
      bus.s_wvalid  = 1'b0;
      bus.s_bready  = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Entered at the negedge of T+1; T is the cycle of the AR handshake.
   task automatic finish_read(input string tag, input logic [31:0] exp_data,
                              input logic [1:0] exp_resp, input int exp_lat, input int stall);
      int lat;
      lat = 1;
      while (!bus.s_rvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".rdata"}, bus.s_rdata, exp_data);
      check({tag, ".rresp"}, 32'(bus.s_rresp), 32'(exp_resp));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, ".stall_rvalid"}, 32'(bus.s_rvalid), 32'd1);
         check({tag, ".stall_rdata"}, bus.s_rdata, exp_data);
      end
      bus.s_rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.s_rready = 1'b0;
      check({tag, ".rvalid_drop"}, 32'(bus.s_rvalid), 32'd0);
   endtask

   // Entered at the negedge of T+1; T is the cycle of the AW/W handshake.
   task automatic finish_write(input string tag, input logic [1:0] exp_bresp, input int stall);
      int lat;
      lat = 1;
      while (!bus.s_bvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".blat"}, 32'(lat), 32'd2);
      check({tag, ".bresp"}, 32'(bus.s_bresp), 32'(exp_bresp));
      check({tag, ".wen_after"}, 32'(bus.perip_wen), 32'd0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, ".stall_bvalid"}, 32'(bus.s_bvalid), 32'd1);
         check({tag, ".stall_bresp"}, 32'(bus.s_bresp), 32'(exp_bresp));
      end
      bus.s_bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.s_bready = 1'b0;
      check({tag, ".bvalid_drop"}, 32'(bus.s_bvalid), 32'd0);
   endtask

   task automatic read_txn(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int exp_lat, input int stall);
      @(negedge clk);
      bus.s_araddr  = addr;
      bus.s_arvalid = 1'b1;
      #1;
      check({tag, ".arready"}, 32'(bus.s_arready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.s_arvalid = 1'b0;
      if (exp_lat > 1) begin
         check({tag, ".perip_addr"}, bus.perip_addr, addr);
         check({tag, ".rd_mask"}, 32'(bus.perip_mask), 32'(MASK_NONE));
      end
      finish_read(tag, exp_data, exp_resp, exp_lat, stall);
   endtask

   task automatic write_txn(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic exp_wen, input logic [1:0] exp_mask,
                            input logic [1:0] exp_bresp, input int stall);
      @(negedge clk);
      bus.s_awaddr  = addr;
      bus.s_wdata   = data;
      bus.s_wstrb   = strb;
      bus.s_awvalid = 1'b1;
      bus.s_wvalid  = 1'b1;
      #1;
      check({tag, ".awready"}, 32'(bus.s_awready), 32'd1);
      check({tag, ".wready"}, 32'(bus.s_wready), 32'd1);
      check({tag, ".wen_before"}, 32'(bus.perip_wen), 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus.s_awvalid = 1'b0;
      bus.s_wvalid  = 1'b0;
      check({tag, ".wen"}, 32'(bus.perip_wen), 32'(exp_wen));
      check({tag, ".mask"}, 32'(bus.perip_mask), 32'(exp_mask));
      check({tag, ".bvalid_early"}, 32'(bus.s_bvalid), 32'd0);
      if (exp_wen) begin
         check({tag, ".perip_addr"}, bus.perip_addr, addr);
         check({tag, ".perip_wdata"}, bus.perip_wdata, data);
      end
      finish_write(tag, exp_bresp, stall);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_rd;
      logic seen;
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.rvalid", 32'(bus.s_rvalid), 32'd0);
      check("rst.bvalid", 32'(bus.s_bvalid), 32'd0);
      check("rst.rdata", bus.s_rdata, 32'd0);
      check("rst.rresp", 32'(bus.s_rresp), 32'd0);
      check("rst.bresp", 32'(bus.s_bresp), 32'd0);
      check("rst.perip_addr", bus.perip_addr, 32'd0);
      check("rst.perip_wdata", bus.perip_wdata, 32'd0);
      check("rst.wen", 32'(bus.perip_wen), 32'd0);
      check("rst.mask", 32'(bus.perip_mask), 32'(MASK_NONE));
      check("rst.arready", 32'(bus.s_arready), 32'd0);
      rst = 1'b0;

      read_txn("rd_beef", 32'h8000_0010, 32'hDEAD_BEEF, RESP_OKAY, RL + 1, 1);
      read_txn("rd_b2b", 32'h8000_0024, 32'h25A5_0024, RESP_OKAY, RL + 1, 0);
      write_txn("wr_word", 32'h8000_0004, 32'h1234_5678, 4'b1111, 1'b1, MASK_WORD, RESP_OKAY, 1);
      write_txn("wr_bad", 32'h8000_0008, 32'hCAFE_F00D, 4'b0101, 1'b0, MASK_NONE, RESP_SLVERR, 0);
      write_txn("wr_byte", 32'h8000_0009, 32'h0000_00AB, 4'b0001, 1'b1, MASK_BYTE, RESP_OKAY, 0);
      write_txn("wr_half", 32'h8000_000A, 32'h0000_BEEF, 4'b0011, 1'b1, MASK_HALF, RESP_OKAY, 0);
      write_txn("wr_upper", 32'h8000_000C, 32'h5500_0000, 4'b1000, 1'b0, MASK_NONE, RESP_SLVERR, 0);

`ifdef PERIP_RANGE_CHECK_EN
      read_txn("rd_oor", 32'h0000_1000, 32'h0000_0000, RESP_DECERR, 1, 1);
      write_txn("wr_oor", 32'h0000_1000, 32'h0000_0077, 4'b1111, 1'b0, MASK_NONE, RESP_DECERR, 0);
`else
      read_txn("rd_far", 32'h0000_1000, 32'hA5A5_1000, RESP_OKAY, RL + 1, 0);
      write_txn("wr_far", 32'h0000_1000, 32'h0000_0077, 4'b0011, 1'b1, MASK_HALF, RESP_OKAY, 0);
`endif

      // Contention from a fresh reset: grants must go R, W, R, W.
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         exp_rd = (i % 2 == 0);
         @(negedge clk);
         bus.s_araddr  = 32'h8000_0020 + 32'(i * 4);
         bus.s_arvalid = 1'b1;
         bus.s_awaddr  = 32'h8000_0100;
         bus.s_wdata   = 32'h1111_0000 + 32'(i);
         bus.s_wstrb   = 4'b1111;
         bus.s_awvalid = 1'b1;
         bus.s_wvalid  = 1'b1;
         #1;
         check($sformatf("arb%0d.arready", i), 32'(bus.s_arready), 32'(exp_rd));
         check($sformatf("arb%0d.awready", i), 32'(bus.s_awready), 32'(!exp_rd));
         check($sformatf("arb%0d.wready", i), 32'(bus.s_wready), 32'(!exp_rd));
         @(posedge clk);
         @(negedge clk);
         bus.s_arvalid = 1'b0;
         bus.s_awvalid = 1'b0;
         bus.s_wvalid  = 1'b0;
         if (exp_rd) begin
            finish_read($sformatf("arb%0d", i), (i == 0) ? 32'h25A5_0020 : 32'h25A5_0028,
                        RESP_OKAY, RL + 1, 3);
         end else begin
            check($sformatf("arb%0d.wen", i), 32'(bus.perip_wen), 32'd1);
            check($sformatf("arb%0d.wdata", i), bus.perip_wdata, 32'h1111_0000 + 32'(i));
            finish_write($sformatf("arb%0d", i), RESP_OKAY, 3);
         end
      end

      // Reset while waiting on read data.
      @(negedge clk);
      bus.s_araddr  = 32'h8000_0030;
      bus.s_arvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.s_arvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_rd.rvalid", 32'(bus.s_rvalid), 32'd0);
      check("rst_rd.mask", 32'(bus.perip_mask), 32'(MASK_NONE));
      rst = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen = seen | bus.s_rvalid;
      end
      check("rst_rd.no_rvalid", 32'(seen), 32'd0);

      // Reset during the write pulse.
      @(negedge clk);
      bus.s_awaddr  = 32'h8000_0040;
      bus.s_wdata   = 32'h0BAD_F00D;
      bus.s_wstrb   = 4'b1111;
      bus.s_awvalid = 1'b1;
      bus.s_wvalid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.s_awvalid = 1'b0;
      bus.s_wvalid  = 1'b0;
      check("rst_wr.pulse", 32'(bus.perip_wen), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_wr.wen", 32'(bus.perip_wen), 32'd0);
      check("rst_wr.mask", 32'(bus.perip_mask), 32'(MASK_NONE));
      check("rst_wr.bvalid", 32'(bus.s_bvalid), 32'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen = seen | bus.s_bvalid | bus.perip_wen;
      end
      check("rst_wr.no_bvalid", 32'(seen), 32'd0);

      read_txn("rd_after_rst", 32'h8000_0010, 32'hDEAD_BEEF, RESP_OKAY, RL + 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
